// File: rtl/flash_stream_reader_pkg.sv
// Shared definitions for the flash stream reader: default widths of the
// DE1 flash controller read port, the reader state encoding and a small
// sizing helper for the word FIFO.
package flash_stream_pkg;

  localparam int FLASH_ADDR_W = 21;
  localparam int FLASH_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // Pointer width for a power-of-two FIFO; a depth of 2 still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/flash_stream_reader_if.sv
// Bundle of the reader's command, output-stream and flash-controller
// signals. The master modport is the reader itself; the slave modport is
// the surrounding system (command source, consumer and flash controller).
interface flash_stream_reader_if
  import flash_stream_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = FLASH_DATA_W
) ();

  // command side
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] word_count;
  logic              abort;
  logic              busy;
  logic              done;

  // output stream
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // flash controller read port
  logic              fl_read_req;
  logic [ADDR_W-1:0] fl_read_addr;
  logic              fl_read_ready;
  logic [DATA_W-1:0] fl_read_data;

  modport master (
    input  start, start_addr, word_count, abort, out_ready,
           fl_read_ready, fl_read_data,
    output busy, done, out_valid, out_data, fl_read_req, fl_read_addr
  );

  modport slave (
    output start, start_addr, word_count, abort, out_ready,
           fl_read_ready, fl_read_data,
    input  busy, done, out_valid, out_data, fl_read_req, fl_read_addr
  );

endinterface

// File: rtl/flash_stream_reader_fifo.sv
// Small synchronous word FIFO (read pointer, write pointer, occupancy
// count). Flush empties it in one cycle and wins over push/pop. The head
// word is read combinationally from storage, so it stays stable while not
// popped.
module flash_word_fifo
  import flash_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CNT_DEPTH);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Write the incoming word at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Advance pointers and occupancy; flush returns everything to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/flash_stream_reader.sv
// Sequential burst reader in front of the DE1 flash controller read port.
// Issues one single-word read at a time starting at a given word address,
// buffers returned words in a small FIFO and streams them out on a
// valid/ready interface. Requests are only issued when the FIFO has room,
// so a returning word can always be stored.
module flash_stream_reader
  import flash_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = FLASH_ADDR_W,
  parameter int DATA_W     = FLASH_DATA_W
) (
  input logic                   clk,
  input logic                   rst,
  flash_stream_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] remaining_r;
  logic [ADDR_W-1:0] remaining_s;
  logic              abort_pend_r;
  logic              abort_pend_s;
  logic              busy_r;
  logic              done_r;
  logic              done_s;
  logic              req_r;
  logic              req_s;

  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              fifo_flush_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [DATA_W-1:0] fifo_dout_s;

  flash_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .flush (fifo_flush_s),
    .din   (bus.fl_read_data),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign fifo_pop_s    = ~fifo_empty_s & bus.out_ready;
  assign bus.out_valid = ~fifo_empty_s;
  assign bus.out_data  = fifo_dout_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.fl_read_req  = req_r;
  assign bus.fl_read_addr = addr_r;

  // Next-state, datapath updates and request/done decisions.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    remaining_s  = remaining_r;
    abort_pend_s = abort_pend_r;
    done_s       = 1'b0;
    req_s        = 1'b0;
    fifo_push_s  = 1'b0;
    fifo_flush_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        abort_pend_s = 1'b0;
        if (bus.start) begin
          if (bus.word_count != ADDR_ZERO) begin
            addr_s       = bus.start_addr;
            remaining_s  = bus.word_count;
            fifo_flush_s = 1'b1;
            state_s      = S_REQ;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.abort) begin
          fifo_flush_s = 1'b1;
          state_s      = S_IDLE;
        end else if (!fifo_full_s) begin
          req_s   = 1'b1;
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        // The controller cannot cancel a read, so an abort is remembered
        // until the outstanding word comes back and is then dropped.
        if (bus.fl_read_ready) begin
          if (abort_pend_r || bus.abort) begin
            abort_pend_s = 1'b0;
            fifo_flush_s = 1'b1;
            state_s      = S_IDLE;
          end else begin
            fifo_push_s = 1'b1;
            addr_s      = addr_r + ADDR_ONE;
            remaining_s = remaining_r - ADDR_ONE;
            if (remaining_r == ADDR_ONE) begin
              state_s = S_FLUSH;
            end else begin
              state_s = S_REQ;
            end
          end
        end else if (bus.abort) begin
          abort_pend_s = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (bus.abort) begin
          fifo_flush_s = 1'b1;
          state_s      = S_IDLE;
        end else if (fifo_empty_s) begin
          done_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_FLUSH;
        end
      end
      default: begin
        abort_pend_s = 1'b0;
        fifo_flush_s = 1'b1;
        state_s      = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Address counter, remaining-word counter and pending-abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r       <= ADDR_ZERO;
      remaining_r  <= ADDR_ZERO;
      abort_pend_r <= 1'b0;
    end else begin
      addr_r       <= addr_s;
      remaining_r  <= remaining_s;
      abort_pend_r <= abort_pend_s;
    end
  end

  // Registered status and request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      req_r  <= 1'b0;
    end else begin
      busy_r <= (state_s != S_IDLE);
      done_r <= done_s;
      req_r  <= req_s;
    end
  end

endmodule

// File: tb/tb_flash_stream_reader.sv
// Directed scoreboard bench for flash_stream_reader. A flash controller
// model answers each request 12 cycles later with addr[15:0]^16'hA5A5 and
// checks request addresses; an output monitor checks streamed words and
// done pulses against queues filled by the stimulus.
module tb_flash_stream_reader;
  import flash_stream_pkg::*;

  localparam int AW  = 21;
  localparam int DW  = 16;
  localparam int LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  flash_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  flash_stream_reader #(
    .FIFO_DEPTH (4),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int req_cnt   = 0;
  int done_cnt  = 0;
  int ready_cyc = 0;
  int mdl_cnt   = 0;
  logic [AW-1:0] mdl_addr;
  logic [AW-1:0] exp_req_q [$];
  logic [DW-1:0] exp_data_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_req_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [AW-1:0] n);
    bus.start_addr = a;
    bus.word_count = n;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, done_cnt - d0, 1);
  endtask

  // Flash controller model: one answer LAT cycles after each request.
  initial begin
    bus.fl_read_ready = 1'b0;
    bus.fl_read_data  = '0;
    forever begin
      @(negedge clk);
      bus.fl_read_ready = 1'b0;
      if (rst) begin
        mdl_cnt = 0;
      end else begin
        if (mdl_cnt > 0) begin
          mdl_cnt--;
          if (mdl_cnt == 0) begin
            bus.fl_read_ready = 1'b1;
            bus.fl_read_data  = mdl_addr[15:0] ^ 16'hA5A5;
            ready_cyc         = cyc;
          end
        end
        if (bus.fl_read_req) begin
          req_cnt++;
          chk("one_outstanding", mdl_cnt, 0);
          if (exp_req_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL req_unexpected: got addr 0x%0h, expected no request", bus.fl_read_addr);
          end else begin
            chk("req_addr", bus.fl_read_addr, exp_req_q.pop_front());
          end
          mdl_addr = bus.fl_read_addr;
          mdl_cnt  = LAT;
        end
      end
    end
  end

  // Output monitor: streamed words and done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_data_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_unexpected: got 0x%0h, expected no word", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, exp_data_q.pop_front());
        end
      end
      if (!rst && bus.done) begin
        done_cnt++;
        chk("done_busy_low", bus.busy, 0);
        chk("done_fifo_empty", bus.out_valid, 0);
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int r0;
    int d0;
    int k;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.word_count = '0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b0;

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_req", bus.fl_read_req, 0);
    chk("rst_addr", bus.fl_read_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // basic burst
    bus.out_ready = 1'b1;
    expect_word(21'h00010, 16'hA5B5);
    expect_word(21'h00011, 16'hA5B4);
    expect_word(21'h00012, 16'hA5B7);
    r0 = req_cnt;
    d0 = done_cnt;
    start_burst(21'h00010, 21'd3);
    chk("basic_busy_after_start", bus.busy, 1);
    wait_done("basic_done", 200);
    repeat (5) tick();
    chk("basic_req_count", req_cnt - r0, 3);
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_data_left", exp_data_q.size(), 0);
    chk("basic_busy_idle", bus.busy, 0);

    // backpressure
    bus.out_ready = 1'b0;
    expect_word(21'h00100, 16'hA4A5);
    expect_word(21'h00101, 16'hA4A4);
    expect_word(21'h00102, 16'hA4A7);
    expect_word(21'h00103, 16'hA4A6);
    expect_word(21'h00104, 16'hA4A1);
    expect_word(21'h00105, 16'hA4A0);
    expect_word(21'h00106, 16'hA4A3);
    expect_word(21'h00107, 16'hA4A2);
    r0 = req_cnt;
    d0 = done_cnt;
    start_burst(21'h00100, 21'd8);
    repeat (150) tick();
    chk("bp_req_stall", req_cnt - r0, 4);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_busy", bus.busy, 1);
    chk("bp_head_word", bus.out_data, 16'hA4A5);
    bus.out_ready = 1'b1;
    wait_done("bp_done", 400);
    repeat (5) tick();
    chk("bp_req_total", req_cnt - r0, 8);
    chk("bp_done_once", done_cnt - d0, 1);
    chk("bp_data_left", exp_data_q.size(), 0);

    // address wrap
    expect_word(21'h1FFFFF, 16'h5A5A);
    expect_word(21'h000000, 16'hA5A5);
    r0 = req_cnt;
    start_burst(21'h1FFFFF, 21'd2);
    wait_done("wrap_done", 200);
    repeat (3) tick();
    chk("wrap_req_count", req_cnt - r0, 2);
    chk("wrap_data_left", exp_data_q.size(), 0);

    // zero word count
    r0 = req_cnt;
    d0 = done_cnt;
    start_burst(21'h00055, 21'd0);
    chk("zero_done_pulse", bus.done, 1);
    chk("zero_busy", bus.busy, 0);
    tick();
    chk("zero_done_single", bus.done, 0);
    chk("zero_busy_after", bus.busy, 0);
    repeat (5) tick();
    chk("zero_no_req", req_cnt - r0, 0);
    chk("zero_done_count", done_cnt - d0, 1);

    // abort while a read is outstanding
    expect_word(21'h00040, 16'hA5E5);
    exp_req_q.push_back(21'h00041);
    r0 = req_cnt;
    d0 = done_cnt;
    start_burst(21'h00040, 21'd5);
    k = 0;
    while (req_cnt < r0 + 2 && k < 100) begin
      tick();
      k++;
    end
    chk("abort_second_req", req_cnt - r0, 2);
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    k = 0;
    while (bus.busy && k < 50) begin
      tick();
      k++;
    end
    chk("abort_busy_drop_cycle", cyc, ready_cyc + 1);
    repeat (20) tick();
    chk("abort_no_more_req", req_cnt - r0, 2);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_data_left", exp_data_q.size(), 0);
    chk("abort_req_left", exp_req_q.size(), 0);

    // asynchronous reset mid-burst with two words buffered
    bus.out_ready = 1'b0;
    expect_word(21'h00200, 16'hA7A5);
    expect_word(21'h00201, 16'hA7A4);
    expect_word(21'h00202, 16'hA7A7);
    r0 = req_cnt;
    start_burst(21'h00200, 21'd4);
    k = 0;
    while (req_cnt < r0 + 3 && k < 100) begin
      tick();
      k++;
    end
    chk("rstmid_third_req", req_cnt - r0, 3);
    chk("rstmid_buffered", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_out_valid", bus.out_valid, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_req", bus.fl_read_req, 0);
    chk("rstmid_addr", bus.fl_read_addr, 0);
    exp_req_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    expect_word(21'h00300, 16'hA6A5);
    expect_word(21'h00301, 16'hA6A4);
    r0 = req_cnt;
    start_burst(21'h00300, 21'd2);
    wait_done("rstmid_restart_done", 200);
    repeat (3) tick();
    chk("rstmid_restart_reqs", req_cnt - r0, 2);
    chk("final_data_left", exp_data_q.size(), 0);
    chk("final_req_left", exp_req_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Sequential burst reader sitting directly upstream of the DE1 flash controller's read port.
- Given a start word address and a word count, issues single-word reads to the flash controller one at a time, holding the address stable for the whole transaction.
- Buffers the returned 16-bit words in a small FIFO and presents them on a valid/ready stream.
- Typical consumers: boot-copy engine (flash to SDRAM) or CPU instruction prefetch.

Parameters:
- FIFO_DEPTH, 4, word FIFO entries; power of two, minimum 2.
- ADDR_W, 21, flash word-address width; matches the controller read_addr.
- DATA_W, 16, word width; matches the controller read_data.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle command strobe; sampled only in S_IDLE.
- start_addr  in  ADDR_W  first word address; latched on accepted start.
- word_count  in  ADDR_W  number of words to read; latched on accepted start.
- abort  in  1  one-cycle cancel of the current burst.
- busy  out  1  high from accepted start until return to S_IDLE.
- done  out  1  one-cycle pulse when the burst is complete and the FIFO is drained.
- out_valid  out  1  FIFO not empty.
- out_data  out  DATA_W  FIFO head word.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fl_read_req  out  1  to controller read_req; one-cycle pulse.
- fl_read_addr  out  ADDR_W  to controller read_addr; registered.
- fl_read_ready  in  1  controller one-cycle data-valid pulse.
- fl_read_data  in  DATA_W  controller data; valid in the fl_read_ready cycle.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, fl_read_req=0, fl_read_addr=0, FIFO empty, state S_IDLE, remaining=0.
- S_IDLE:
  - start with word_count!=0: latch addr and remaining, flush FIFO, busy=1 next cycle, go to S_REQ.
  - start with word_count==0: done pulses the next cycle, busy stays 0.
  - start while busy: ignored.
- S_REQ:
  - FIFO not full: fl_read_req=1 for exactly one cycle, go to S_WAIT.
  - FIFO full: stall in S_REQ with fl_read_req=0.
- S_WAIT:
  - fl_read_addr is held constant; the controller drives the flash address from it combinationally.
  - On fl_read_ready: push fl_read_data, fl_read_addr+1 (wraps 2^ADDR_W-1 to 0), remaining-1.
  - Next state: S_FLUSH if remaining was 1, else S_REQ.
  - At most one read is outstanding at any time.
- S_FLUSH: wait until the FIFO is empty; then done=1 for one cycle, busy=0, go to S_IDLE.
- Minimum request spacing: one idle cycle between fl_read_ready and the next fl_read_req. This is guaranteed because S_REQ follows S_WAIT.
- FIFO:
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - A push never occurs while full, because a request is issued only when not full.
  - out_data is stable while out_valid & !out_ready.
- Abort:
  - In S_REQ or S_FLUSH: flush FIFO, go to S_IDLE next cycle. No done pulse.
  - In S_WAIT: latch abort_pend and stay in S_WAIT until fl_read_ready. The controller cannot cancel a read. Then discard the data, flush, go to S_IDLE. No done pulse.
  - abort in S_IDLE: ignored.
  - Simultaneous abort and fl_read_ready in S_WAIT: data discarded, S_IDLE next cycle.
- Async reset mid-burst returns every output to its reset value immediately. The flash controller shares rst, so no stale fl_read_ready is expected afterwards.
- Width rules: remaining and the address counter are ADDR_W bits, unsigned, modulo arithmetic.

Decomposition:
- Package flash_stream_pkg:
  - FLASH_ADDR_W=21, FLASH_DATA_W=16.
  - State enum {S_IDLE, S_REQ, S_WAIT, S_FLUSH}.
- Sub-module flash_word_fifo: synchronous FIFO.
  - Parameters DEPTH, WIDTH.
  - Ports push, pop, flush, din, dout, empty, full.
  - Pointer-plus-count implementation.

Test Plan:
- Bench controller model: answers each req after 12 cycles with data=addr[15:0]^16'hA5A5.
- Basic burst: start_addr=0x00010, word_count=3, out_ready=1 -> out words 0xA5B5, 0xA5B4, 0xA5B7; three fl_read_req pulses at addrs 0x10, 0x11, 0x12; single done pulse after the last pop; busy low the same cycle.
- Backpressure: word_count=8, out_ready=0 -> exactly 4 reqs issued, then fl_read_req held 0. Release out_ready -> remaining 4 words in order, done once.
- Wrap: start_addr=0x1FFFFF, word_count=2 -> request addresses 0x1FFFFF then 0x000000.
- Zero count: start with word_count=0 -> done pulse one cycle later, no fl_read_req, busy never 1.
- Abort in S_WAIT: abort 3 cycles after the 2nd req of a 5-word burst -> no further reqs. busy drops the cycle after that req's fl_read_ready. out_valid=0 and no done pulse.
- Async reset mid-burst: assert rst with 2 words buffered -> out_valid=0, busy=0, fl_read_req=0 immediately. A new start after release runs cleanly.
